axis_master_data_gen_test: RTL and testbench
============================================

// Module: axis_master_data_gen_test
// PURPOSE
//  AXI4-Stream master test source for the krnl_vadd benches: on a start pulse it emits a burst of
//  C_NUM_WORDS incrementing data words with TLAST on the final beat.
//  Drives the DUT stream input, or the stream-sink test receiver, in tb/ loopback benches.
//  Reports completion through a done pulse and a running beat count.
// PARAMETERS
//  C_M_AXIS_TDATA_WIDTH  32    TDATA width in bits (multiple of 8)
//  C_NUM_WORDS           1024  beats per burst (>=1)
//  C_START_VALUE         0     TDATA of beat 0; beat k carries C_START_VALUE+k mod 2^W
//  C_BUBBLE_PERIOD       8     accepted beats between injected bubbles (AXIS_TX_BUBBLE_EN only)
//  C_BUBBLE_LEN          4     TVALID-low cycles per bubble (AXIS_TX_BUBBLE_EN only)
// PORTS
//  M_AXIS_ACLK     in   1    clock, all logic on rising edge
//  M_AXIS_ARESETN  in   1    asynchronous active-low reset
//  start           in   1    1-cycle request to send one burst; ignored unless IDLE
//  busy            out  1    1 while in SEND
//  done            out  1    1-cycle pulse after last beat accepted
//  beat_cnt        out  CW   beats accepted in current/last burst, CW=clogb2(C_NUM_WORDS+1)
//  M_AXIS_TVALID   out  1    data valid
//  M_AXIS_TDATA    out  W    payload
//  M_AXIS_TSTRB    out  W/8  byte qualifier, constant all-ones
//  M_AXIS_TLAST    out  1    marks beat C_NUM_WORDS-1
//  M_AXIS_TREADY   in   1    sink ready
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; TVALID=0, TLAST=0, TDATA=0, busy=0, done=0,
//    beat_cnt=0. Asserting reset mid-burst abandons the burst. TVALID falls with reset, no handshake.
//  - All outputs registered; TSTRB tied to {W/8{1'b1}}.
//  - FSM IDLE->SEND->DONE->IDLE.
//    IDLE: start=1 -> SEND. beat_cnt cleared, TDATA=C_START_VALUE, TVALID=1 on the next edge.
//      Latency is start -> TVALID = 1 cycle.
//    SEND: transfer = TVALID&&TREADY. On a transfer, beat_cnt+1 and TDATA+1 (wraps at 2^W).
//      TLAST=1 exactly while beat_cnt==C_NUM_WORDS-1.
//      While TVALID&&!TREADY, TDATA/TLAST/TVALID are held stable (AXIS rule; never retract valid).
//      A transfer with TLAST=1 -> DONE. TVALID and TLAST are 0 the following cycle.
//    DONE: done=1 for exactly one cycle -> IDLE. beat_cnt holds C_NUM_WORDS until the next start.
//  - C_NUM_WORDS=1: the first beat carries TLAST=1.
//  - A start in SEND/DONE is dropped, not queued. A start in the same cycle as done is dropped.
//  - TREADY held high: one beat per cycle, burst occupies exactly C_NUM_WORDS SEND cycles.
//  - TREADY toggling has no effect when TVALID=0.
// CONFIGURATION
//  AXIS_TX_BUBBLE_EN defined:
//    - After every C_BUBBLE_PERIOD accepted beats (excluding the TLAST beat), TVALID drops for
//      exactly C_BUBBLE_LEN cycles, then resumes with the next data value.
//    - The drop happens only on the cycle after a transfer, never while a beat is pending.
//    - Bubble counters reset on start.
//  AXIS_TX_BUBBLE_EN undefined: TVALID stays high through all of SEND. Bubble params are unused.
// TESTING
//  1 TREADY=1, start at t0, defaults -> TVALID at t0+1; 1024 beats data 0..1023 on consecutive
//    cycles; TLAST only on 1023; done one cycle after; beat_cnt=1024.
//  2 TREADY low 5 cycles on beat 3 -> TDATA=3, TVALID=1, TLAST=0 held all 5 cycles; no beat lost or duplicated.
//  3 C_NUM_WORDS=1, C_START_VALUE=32'hFFFF_FFFF -> single beat FFFF_FFFF with TLAST=1; done next cycle.
//  4 C_START_VALUE=32'hFFFF_FFFE, C_NUM_WORDS=4 -> data FFFF_FFFE, FFFF_FFFF, 0, 1; TLAST on 1.
//  5 ARESETN low at beat 500, then start again -> TVALID=0 immediately; new burst restarts at 0 with beat_cnt=0.
//  6 AXIS_TX_BUBBLE_EN, TREADY=1 -> after beats 7, 15, ... TVALID is low 4 cycles.
//    Repeated start pulses while busy -> no second burst.

Source files
------------

// File: rtl/axis_master_data_gen_test.sv
// axis_master_data_gen_test: AXI4-Stream source emitting C_NUM_WORDS incrementing beats per start pulse.
// Defining AXIS_TX_BUBBLE_EN injects C_BUBBLE_LEN TVALID-low cycles after every C_BUBBLE_PERIOD beats.
module axis_master_data_gen_test #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_NUM_WORDS = 1024,
  parameter logic [C_M_AXIS_TDATA_WIDTH-1:0] C_START_VALUE = '0,
  parameter int C_BUBBLE_PERIOD = 8,
  parameter int C_BUBBLE_LEN = 4,
  localparam int CW = $clog2(C_NUM_WORDS + 1)
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [CW-1:0]                       beat_cnt,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);
  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(C_NUM_WORDS - 1);
  if (C_NUM_WORDS < 1 || W % 8 != 0 || C_BUBBLE_PERIOD < 1 || C_BUBBLE_LEN < 1) begin : g_bad_cfg
    $error("axis_master_data_gen_test: invalid parameter set");
  end
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d, done_q, done_d;
  logic [W-1:0] tdata_q, tdata_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic xfer;
  assign xfer = tvalid_q && M_AXIS_TREADY;
`ifdef AXIS_TX_BUBBLE_EN
  localparam int PW = $clog2(C_BUBBLE_PERIOD + 1);
  localparam int LW = $clog2(C_BUBBLE_LEN + 1);
  logic [PW-1:0] per_q, per_d;
  logic [LW-1:0] gap_q, gap_d;
`endif
  always_comb begin
    state_d = state_q;
    tvalid_d = tvalid_q;
    tdata_d = tdata_q;
    beat_cnt_d = beat_cnt_q;
`ifdef AXIS_TX_BUBBLE_EN
    per_d = per_q;
    gap_d = gap_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        tvalid_d = 1'b1;
        tdata_d = C_START_VALUE;
        beat_cnt_d = '0;
`ifdef AXIS_TX_BUBBLE_EN
        per_d = '0;
        gap_d = '0;
`endif
      end
      SEND: if (xfer) begin
        beat_cnt_d = beat_cnt_q + CW'(1);
        tdata_d = tdata_q + W'(1);
        if (tlast_q) begin
          state_d = DONE;
          tvalid_d = 1'b0;
        end
`ifdef AXIS_TX_BUBBLE_EN
        else if (per_q == PW'(C_BUBBLE_PERIOD - 1)) begin
          tvalid_d = 1'b0;
          per_d = '0;
          gap_d = LW'(C_BUBBLE_LEN);
        end else per_d = per_q + PW'(1);
`endif
      end
`ifdef AXIS_TX_BUBBLE_EN
      else if (!tvalid_q) begin
        gap_d = gap_q - LW'(1);
        tvalid_d = gap_q == LW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = state_d == SEND;
    done_d = state_d == DONE;
    // TLAST only accompanies a valid final beat, so it is also low during bubbles
    tlast_d = busy_d && tvalid_d && beat_cnt_d == LAST_IDX;
  end
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) begin
      state_q <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      beat_cnt_q <= '0;
`ifdef AXIS_TX_BUBBLE_EN
      per_q <= '0;
      gap_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef AXIS_TX_BUBBLE_EN
      per_q <= per_d;
      gap_q <= gap_d;
`endif
    end
  assign busy = busy_q;
  assign done = done_q;
  assign beat_cnt = beat_cnt_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA = tdata_q;
  assign M_AXIS_TSTRB = '1;
  assign M_AXIS_TLAST = tlast_q;
endmodule

// File: tb/tb_axis_master_data_gen_test.sv
// tb_axis_master_data_gen_test: three source instances (1024 beats, 4 beats wrapping, 1 beat) checked by a
// beat scoreboard plus a table of burst scenarios.
module tb_axis_master_data_gen_test;
  localparam int NW [3] = '{1024, 4, 1};
  localparam logic [31:0] SV [3] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
`ifdef AXIS_TX_BUBBLE_EN
  localparam int BP = 8, BL = 4, BUB0 = ((1024 - 1) / 8) * 4;
`else
  localparam int BUB0 = 0;
`endif
  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { int sel; int stall_at; int stall_len; bit dbl; int cyc; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start [3], tready [3], tvalid [3], tlast [3], busy [3], done [3];
  logic [31:0] tdata [3];
  logic [3:0] tstrb [3];
  logic [10:0] bc0;
  logic [2:0] bc1;
  logic [0:0] bc2;
  int bc [3];
  int n_tests = 0, n_fail = 0;
  beat_t sb [3][$];
  beat_t mon_e;
  int acc [3], exp_low [3];
  logic [31:0] pdata [3];
  logic pstall [3], plast [3];
  vec_t vt [6];
  assign bc[0] = int'(bc0);
  assign bc[1] = int'(bc1);
  assign bc[2] = int'(bc2);
  always #5 clk = ~clk;
  axis_master_data_gen_test u0 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .beat_cnt(bc0), .M_AXIS_TVALID(tvalid[0]), .M_AXIS_TDATA(tdata[0]), .M_AXIS_TSTRB(tstrb[0]),
    .M_AXIS_TLAST(tlast[0]), .M_AXIS_TREADY(tready[0]));
  axis_master_data_gen_test #(.C_NUM_WORDS(4), .C_START_VALUE(32'hFFFF_FFFE)) u1 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .beat_cnt(bc1), .M_AXIS_TVALID(tvalid[1]), .M_AXIS_TDATA(tdata[1]), .M_AXIS_TSTRB(tstrb[1]),
    .M_AXIS_TLAST(tlast[1]), .M_AXIS_TREADY(tready[1]));
  axis_master_data_gen_test #(.C_NUM_WORDS(1), .C_START_VALUE(32'hFFFF_FFFF)) u2 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .beat_cnt(bc2), .M_AXIS_TVALID(tvalid[2]), .M_AXIS_TDATA(tdata[2]), .M_AXIS_TSTRB(tstrb[2]),
    .M_AXIS_TLAST(tlast[2]), .M_AXIS_TREADY(tready[2]));
  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Monitor: pops the scoreboard on each handshake and checks AXIS stability rules.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pstall[i]) begin
        chk("hold_valid", longint'(tvalid[i]), 1);
        chk("hold_data", longint'(tdata[i]), longint'(pdata[i]));
        chk("hold_last", longint'(tlast[i]), longint'(plast[i]));
      end
      if (!tvalid[i]) chk("tlast_idle", longint'(tlast[i]), 0);
      if (exp_low[i] > 0) begin
        chk("bubble_low", longint'(tvalid[i]), 0);
        exp_low[i]--;
      end
      if (tvalid[i] && tready[i]) begin
        if (sb[i].size() == 0) chk("extra_beat", longint'(tdata[i]), -1);
        else begin
          mon_e = sb[i].pop_front();
          chk("beat_data", longint'(tdata[i]), longint'(mon_e.data));
          chk("beat_last", longint'(tlast[i]), longint'(mon_e.last));
        end
        acc[i]++;
`ifdef AXIS_TX_BUBBLE_EN
        if (acc[i] % BP == 0 && acc[i] != NW[i]) exp_low[i] = BL;
`endif
      end
      pstall[i] = tvalid[i] && !tready[i];
      pdata[i] = tdata[i];
      plast[i] = tlast[i];
    end
  end
  task automatic push_burst(input int sel);
    logic [31:0] d;
    d = SV[sel];
    for (int k = 0; k < NW[sel]; k++) begin
      sb[sel].push_back('{d, k == NW[sel] - 1});
      d++;
    end
    acc[sel] = 0;
  endtask
  task automatic run(input vec_t v);
    int cyc, stalled, s;
    logic [31:0] sd;
    s = v.sel;
    sd = SV[s] + 32'(v.stall_at);
    stalled = 0;
    push_burst(s);
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    cyc = 1;
    chk("valid_latency", longint'(tvalid[s]), 1);
    chk("busy_send", longint'(busy[s]), 1);
    chk("first_data", longint'(tdata[s]), longint'(SV[s]));
    chk("bc_cleared", bc[s], 0);
    while (!done[s] && cyc < 5000) begin
      tready[s] = !(bc[s] == v.stall_at && stalled < v.stall_len);
      if (!tready[s]) begin
        stalled++;
        chk("stall_data", longint'(tdata[s]), longint'(sd));
        chk("stall_valid", longint'(tvalid[s]), 1);
        chk("stall_last", longint'(tlast[s]), longint'(v.stall_at == NW[s] - 1));
      end
      start[s] = v.dbl && (cyc == 3 || cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    tready[s] = 1'b1;
    start[s] = 1'b0;
    chk("burst_cycles", cyc, v.cyc);
    chk("done_bc", bc[s], NW[s]);
    chk("done_valid", longint'(tvalid[s]), 0);
    chk("done_busy", longint'(busy[s]), 0);
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    chk("done_pulse_len", longint'(done[s]), 0);
    for (int k = 0; k < 4; k++) begin
      tready[s] = k[0];
      @(posedge clk); #1;
      chk("no_restart", longint'(tvalid[s]), 0);
    end
    tready[s] = 1'b1;
    chk("sb_empty", sb[s].size(), 0);
    chk("bc_hold", bc[s], NW[s]);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      tready[i] = 1'b1;
      acc[i] = 0;
      exp_low[i] = 0;
      pstall[i] = 1'b0;
    end
    vt[0] = '{0, 3, 5, 1'b0, 1030 + BUB0};
    vt[1] = '{1, -1, 0, 1'b0, 5};
    vt[2] = '{2, -1, 0, 1'b0, 2};
    vt[3] = '{1, 3, 2, 1'b0, 7};
    vt[4] = '{0, -1, 0, 1'b1, 1025 + BUB0};
    vt[5] = '{2, 0, 3, 1'b0, 5};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", longint'(tvalid[i]), 0);
      chk("rst_last", longint'(tlast[i]), 0);
      chk("rst_data", longint'(tdata[i]), 0);
      chk("rst_busy", longint'(busy[i]), 0);
      chk("rst_done", longint'(done[i]), 0);
      chk("rst_bc", bc[i], 0);
      chk("tstrb", longint'(tstrb[i]), 15);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_burst(0);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (bc[0] != 500 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat_500", bc[0], 500);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(tvalid[0]), 0);
    chk("midrst_bc", bc[0], 0);
    chk("midrst_busy", longint'(busy[0]), 0);
    chk("midrst_data", longint'(tdata[0]), 0);
    sb[0].delete();
    exp_low[0] = 0;
    pstall[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", longint'(tvalid[0]), 0);
    for (int i = 0; i < 6; i++) run(vt[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
